// File: rtl/io_dmem_read_arbiter.sv
// io_dmem_read_arbiter: shares the controller's single read request/response
// channel pair between two IO masters. Whole bursts are granted round-robin,
// one burst outstanding at a time, and each response beat is steered back to
// the master that owns the current burst.
`timescale 1ns/1ps
module io_dmem_read_arbiter #(
    parameter int AWIDTH        = 14,
    parameter int DWIDTH        = 32,
    parameter int MAX_BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] m0_req_read_addr,
    input  logic [31:0]       m0_req_read_len,
    input  logic              m0_req_read_addr_valid,
    output logic              m0_req_read_addr_ready,
    output logic [DWIDTH-1:0] m0_resp_read_data,
    output logic              m0_resp_read_data_valid,
    input  logic              m0_resp_read_data_ready,
    input  logic [AWIDTH-1:0] m1_req_read_addr,
    input  logic [31:0]       m1_req_read_len,
    input  logic              m1_req_read_addr_valid,
    output logic              m1_req_read_addr_ready,
    output logic [DWIDTH-1:0] m1_resp_read_data,
    output logic              m1_resp_read_data_valid,
    input  logic              m1_resp_read_data_ready,
    output logic [AWIDTH-1:0] req_read_addr,
    output logic [31:0]       req_read_len,
    output logic              req_read_addr_valid,
    input  logic              req_read_addr_ready,
    input  logic [DWIDTH-1:0] resp_read_data,
    input  logic              resp_read_data_valid,
    output logic              resp_read_data_ready,
    output logic              err_len
);

    localparam int BW = $clog2(MAX_BURST_LEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [31:0]       len_q, len_d;
    logic [BW-1:0]     beats_q, beats_d;
    logic              err_q, err_d;

    logic              gnt0, gnt1, gnt_any, win;
    logic [AWIDTH-1:0] win_addr;
    logic [31:0]       win_len;
    logic              win_len_ok;
    logic              in_burst;
    logic              resp_fire;

    // Grant decision: a lone requester wins; on a tie the master that was not
    // served last wins. Held off during reset so readies read 0 there.
    assign gnt0       = rst && (state_q == S_IDLE) && m0_req_read_addr_valid &&
                        (!m1_req_read_addr_valid || last_q);
    assign gnt1       = rst && (state_q == S_IDLE) && m1_req_read_addr_valid &&
                        (!m0_req_read_addr_valid || !last_q);
    assign gnt_any    = gnt0 || gnt1;
    assign win        = gnt1;
    assign win_addr   = gnt1 ? m1_req_read_addr : m0_req_read_addr;
    assign win_len    = gnt1 ? m1_req_read_len : m0_req_read_len;
    // Full 32-bit compare so large lengths never alias onto a legal value.
    assign win_len_ok = (win_len != 32'd0) && (win_len <= 32'(MAX_BURST_LEN));
    assign in_burst   = (state_q == S_BURST);
    assign resp_fire  = resp_read_data_valid && resp_read_data_ready;

    // State register: every register returns to its idle value on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: grant/latch in IDLE, hand-off in ISSUE, beat count in BURST.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beats_d = beats_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    addr_d  = win_addr;
                    len_d   = win_len;
                    owner_d = win;
                    if (win_len_ok) begin
                        state_d = S_ISSUE;
                    end else begin
                        // Dropped request still counts as a turn for fairness.
                        err_d  = 1'b1;
                        last_d = win;
                    end
                end
            end
            S_ISSUE: begin
                if (req_read_addr_ready) begin
                    beats_d = len_q[BW-1:0];
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (resp_fire) begin
                    beats_d = beats_q - 1'b1;
                    if (beats_q == BW'(1)) begin
                        last_d  = owner_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: request forwarding and combinational response routing.
    always_comb begin
        m0_req_read_addr_ready  = gnt0;
        m1_req_read_addr_ready  = gnt1;
        req_read_addr_valid     = (state_q == S_ISSUE);
        req_read_addr           = addr_q;
        req_read_len            = len_q;
        resp_read_data_ready    = in_burst && (owner_q ? m1_resp_read_data_ready
                                                       : m0_resp_read_data_ready);
        m0_resp_read_data_valid = in_burst && !owner_q && resp_read_data_valid;
        m1_resp_read_data_valid = in_burst &&  owner_q && resp_read_data_valid;
        m0_resp_read_data       = (in_burst && !owner_q) ? resp_read_data : '0;
        m1_resp_read_data       = (in_burst &&  owner_q) ? resp_read_data : '0;
        err_len                 = err_q;
    end

endmodule

// File: doc/io_dmem_read_arbiter.md
# io_dmem_read_arbiter

Two-requester arbiter for the read side of `io_dmem_controller`. It shares the single read request and read response channel pair between two IO masters, m0 and m1 (for example, the UART DMA path and an accelerator). It grants whole bursts round-robin and routes each response beat back to the master that owns the burst. Only one burst is outstanding at a time. The block sits between the masters and the controller's `req_read_*` and `resp_read_*` ports.

## Interface
- `AWIDTH`, default 14: DMem word-address width.
- `DWIDTH`, default 32: data width.
- `MAX_BURST_LEN`, default 8: largest legal burst length.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `m0_req_read_addr` / `m1_req_read_addr`  in  AWIDTH  start word address of the burst.
- `m0_req_read_len` / `m1_req_read_len`  in  32  burst length in beats.
- `m0_req_read_addr_valid` / `m1_req_read_addr_valid`  in  1  request valid.
- `m0_req_read_addr_ready` / `m1_req_read_addr_ready`  out  1  request accepted by the arbiter.
- `m0_resp_read_data` / `m1_resp_read_data`  out  DWIDTH  routed response data.
- `m0_resp_read_data_valid` / `m1_resp_read_data_valid`  out  1  routed response valid.
- `m0_resp_read_data_ready` / `m1_resp_read_data_ready`  in  1  master can accept a beat.
- `req_read_addr`  out  AWIDTH  address to the controller.
- `req_read_len`  out  32  length to the controller.
- `req_read_addr_valid`  out  1  request valid to the controller.
- `req_read_addr_ready`  in  1  controller accepts the request.
- `resp_read_data`  in  DWIDTH  beat from the controller.
- `resp_read_data_valid`  in  1  beat valid from the controller.
- `resp_read_data_ready`  out  1  ready to the controller.
- `err_len`  out  1  one-cycle pulse when a request is dropped for an illegal length.

## Operation
- **States:** IDLE, ISSUE, BURST.
- **`last` register:** 1 bit, records the most recently granted master. Reset value 1, so m0 wins first.
- **IDLE:**
  - If exactly one `mX_req_read_addr_valid` is high, that master wins.
  - If both are high, the master not equal to `last` wins.
  - In the same cycle, assert the winner's `req_read_addr_ready` combinationally (the loser's stays 0), then latch addr, len and owner.
- **Length check** at grant:
  - If len is 0 or greater than `MAX_BURST_LEN`: the request is still accepted (ready=1). Next cycle, `err_len`=1 for one cycle. Nothing is forwarded, `last` is updated, and the state stays IDLE.
  - Otherwise, go to ISSUE.
- **ISSUE:**
  - `req_read_addr_valid`=1 with the latched addr and len, held stable until `req_read_addr_ready`.
  - On fire, load `beats` = len and go to BURST.
- **BURST:**
  - The owner's data, valid and ready are wired to the controller's response channel.
  - The non-owner sees `resp_read_data_valid`=0 and `resp_read_data`=0.
  - `beats` decrements on each response fire (valid & ready).
  - On the fire with `beats`==1: set `last` = owner and go to IDLE.
- **Outside BURST:** `resp_read_data_ready`=0, and both masters' response valids are 0.
- **Arithmetic:** `beats` is $clog2(MAX_BURST_LEN)+1 bits wide; the length compare is done on the full 32 bits.

## Timing
- **Reset values:**
  - All valid and ready outputs are 0.
  - `err_len`=0; `req_read_addr`=0; `req_read_len`=0.
  - State = IDLE; `last`=1; `beats`=0.
- **Reset mid-burst:** the next cycle is in IDLE with all outputs at reset values. The controller shares `rst`, so no stale beats arrive.
- **Request latency:** a master's valid sampled in IDLE at edge N produces `req_read_addr_valid` high from edge N+1.
- **Turnaround:** the cycle after the last beat is IDLE, so a new grant can be made there. Minimum gap between bursts is one IDLE cycle.
- **Beat throughput:** one beat per cycle is passed through combinationally (no added latency). Master backpressure propagates to the controller in the same cycle.
- **No-drop rule:** with `mX_resp_read_data_ready`=0, no beat is lost and `beats` holds.
- **Requester rule:** once a master's request is accepted, it must not expect a second ready for that request. The arbiter ignores valid changes after the grant.

## Test plan
- **Single burst:** DMem[i]=i*100; m0 requests addr 10, len 8 -> m0 receives 1000,1100,…,1700 in order; m1 valid stays 0; exactly 8 response fires.
- **Simultaneous requests:** after reset, m0 and m1 request in the same cycle (addr 10 and 40, len 4) -> m0 is served first (1000..1300), then m1 (4000..4300).
- **Fairness:** m0 holds valid continuously while m1 requests once -> the grant order is m0, m1, m0.
- **Backpressure:** m1 burst at addr 20, len 8, with `m1_resp_read_data_ready` toggling every cycle -> all 8 values 2000..2700 are delivered, none duplicated.
- **Illegal lengths:** m0 len 0, then len 9 -> the m0 ready pulses each time, `err_len` pulses twice, `req_read_addr_valid` is never asserted, and the next legal request is served normally.
- **Reset mid-burst:** assert `rst`=0 after 3 of 8 beats -> the next cycle has all outputs at 0; after release, a new m1 request completes correctly.
